jt12_pg_seq: RTL and testbench

- Slot sequencer for the phase-generator datapath, jt12_pg_comb.
- Steps a 24-slot operator counter (6 channels × 4 operators) and stores the 20-bit phase accumulator for every slot.
- Presents the current slot's phase and reset request to the combinational PG, then writes the new phase back.
- Buffers asynchronous key-on events per slot until that slot's turn comes.

---
 rtl/jt12_pg_seq.sv | 195 +++++++++++++++++++
 tb/tb_jt12_pg_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jt12_pg_seq.sv
// ---------------------------------------------------------------------------
// jt12_pg_seq
//
// Slot sequencer for the phase-generator datapath (jt12_pg_comb). It sweeps
// the 24 operator slots (6 channels x 4 operators) in round-robin order. For
// each slot it holds the 20-bit phase accumulator, presents that phase and a
// pending key-on reset to the combinational PG, and writes the new phase back.
// Key-on events can arrive at any time for any slot. Each one is latched in a
// per-slot pending bit until the sweep reaches that slot.
//
// After reset the sequencer runs a clear sweep (INIT) that zeroes every phase
// word. It then moves to RUN, where one slot is processed per clk with cen=1.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-high
//   cen           clock enable: one slot is processed per clk with cen=1 (RUN)
//   kon_req       key-on request, sampled every clk
//   kon_slot      slot index for kon_req (values >= SLOTS are ignored)
//   kon_ack       one-clk pulse, the clk after an accepted kon_req
//   busy          high while the post-reset clear sweep runs
//   slot          slot currently presented to the PG
//   sync          high while slot==0 in RUN
//   pg_phase_in   stored phase of the current slot (to PG phase_in)
//   pg_rst        key-on phase reset for the current slot (to PG pg_rst)
//   pg_phase_out  next phase from the PG
//   pg_phase_op   operator phase from the PG
//   phase_op      registered operator phase
//   op_slot       slot that phase_op belongs to
//   op_valid      one-clk pulse when phase_op/op_slot update
// ---------------------------------------------------------------------------
module jt12_pg_seq #(
    parameter int SLOTS = 24,
    parameter int PW    = 20,
    parameter int OPW   = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           kon_req,
    input  logic [4:0]     kon_slot,
    output logic           kon_ack,
    output logic           busy,
    output logic [4:0]     slot,
    output logic           sync,
    output logic [PW-1:0]  pg_phase_in,
    output logic           pg_rst,
    input  logic [PW-1:0]  pg_phase_out,
    input  logic [OPW-1:0] pg_phase_op,
    output logic [OPW-1:0] phase_op,
    output logic [4:0]     op_slot,
    output logic           op_valid
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

    state_t state;
    state_t next_state;

    logic [PW-1:0]    mem [SLOTS];
    logic [SLOTS-1:0] pending;
    logic [SLOTS-1:0] pending_next;

    logic at_last;
    logic run_step;
    logic kon_hit;

    assign at_last  = (slot == LAST_SLOT);
    // A slot is processed only in RUN on a clk with cen.
    assign run_step = (state == ST_RUN) && cen;
    // Requests aimed beyond the last slot are dropped and never acked.
    assign kon_hit  = kon_req && (kon_slot <= LAST_SLOT);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default first,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_INIT: if (at_last) next_state = ST_RUN;
            ST_RUN:  next_state = ST_RUN;
            default: next_state = ST_INIT;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output logic
    // -----------------------------------------------------------------------
    // During INIT the PG is held in reset and sees a zero phase. It does not
    // read the memory there because the memory is still being cleared.
    always_comb begin
        busy        = 1'b1;
        sync        = 1'b0;
        pg_rst      = 1'b1;
        pg_phase_in = '0;
        case (state)
            ST_RUN: begin
                busy        = 1'b0;
                sync        = (slot == 5'd0);
                pg_rst      = pending[slot];
                pg_phase_in = mem[slot];
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Slot counter: free-running in INIT, cen-gated in RUN, wraps at the
    // last slot so it never exceeds SLOTS-1.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot <= 5'd0;
        end else if ((state == ST_INIT) || cen) begin
            slot <= at_last ? 5'd0 : slot + 5'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Phase memory
    // -----------------------------------------------------------------------
    // NOTE: the phase memory has no reset port so it can map onto RAM. The
    // INIT sweep clears it one word per clk instead.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[slot] <= '0;
        end else if (cen) begin
            mem[slot] <= pg_phase_out;
        end
    end

    // -----------------------------------------------------------------------
    // Key-on pending mask. The clear for the processed slot is applied
    // before the set. A request for that same slot on the same clk
    // therefore survives and takes effect on the slot's next visit.
    // -----------------------------------------------------------------------
    always_comb begin
        pending_next = pending;
        if (run_step) begin
            pending_next[slot] = 1'b0;
        end
        if (kon_hit) begin
            pending_next[kon_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            kon_ack <= 1'b0;
        end else begin
            pending <= pending_next;
            kon_ack <= kon_hit;
        end
    end

    // -----------------------------------------------------------------------
    // Operator phase output register: captures the PG result for the slot
    // processed on this clk. It becomes visible one clk later.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_op <= '0;
            op_slot  <= 5'd0;
            op_valid <= 1'b0;
        end else begin
            op_valid <= run_step;
            if (run_step) begin
                phase_op <= pg_phase_op;
                op_slot  <= slot;
            end
        end
    end

endmodule

// File: tb/tb_jt12_pg_seq.sv
// ---------------------------------------------------------------------------
// tb_jt12_pg_seq
//
// Self-checking bench for jt12_pg_seq. A behavioural PG sits around the DUT.
// Its next phase is 0 while pg_rst is high, otherwise phase+100, and its
// operator phase is the low OPW bits of that next phase. A reference model
// tracks the state, slot, phases and pending mask of the sequencer. Each
// processed slot pushes its expected (slot, phase_op) pair onto a queue. The
// pair is popped and compared when the DUT raises op_valid.
// Inputs change on the falling edge. Outputs are sampled away from the
// rising edge.
// ---------------------------------------------------------------------------
module tb_jt12_pg_seq;

    localparam int SLOTS = 24;
    localparam int PW    = 20;
    localparam int OPW   = 10;

    logic           clk;
    logic           rst;
    logic           cen;
    logic           kon_req;
    logic [4:0]     kon_slot;
    logic           kon_ack;
    logic           busy;
    logic [4:0]     slot;
    logic           sync;
    logic [PW-1:0]  pg_phase_in;
    logic           pg_rst;
    logic [PW-1:0]  pg_phase_out;
    logic [OPW-1:0] pg_phase_op;
    logic [OPW-1:0] phase_op;
    logic [4:0]     op_slot;
    logic           op_valid;

    jt12_pg_seq #(.SLOTS(SLOTS), .PW(PW), .OPW(OPW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cen          (cen),
        .kon_req      (kon_req),
        .kon_slot     (kon_slot),
        .kon_ack      (kon_ack),
        .busy         (busy),
        .slot         (slot),
        .sync         (sync),
        .pg_phase_in  (pg_phase_in),
        .pg_rst       (pg_rst),
        .pg_phase_out (pg_phase_out),
        .pg_phase_op  (pg_phase_op),
        .phase_op     (phase_op),
        .op_slot      (op_slot),
        .op_valid     (op_valid)
    );

    // Behavioural phase generator.
    assign pg_phase_out = pg_rst ? '0 : pg_phase_in + 20'd100;
    assign pg_phase_op  = pg_phase_out[OPW-1:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model.
    typedef struct packed {
        logic [4:0]     s;
        logic [OPW-1:0] op;
    } exp_t;

    exp_t             exp_q [$];
    logic [PW-1:0]    m_mem [SLOTS];
    logic [SLOTS-1:0] m_pending;
    logic [4:0]       m_slot;
    logic             m_run;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        m_slot    = 5'd0;
        m_pending = '0;
        exp_q.delete();
    endtask

    // One clk: drive inputs, check combinational outputs, advance the model,
    // cross the rising edge and check registered outputs.
    task automatic tick(input logic c, input logic kreq, input logic [4:0] ks);
        logic          exp_ack;
        logic          exp_valid;
        logic [PW-1:0] nxt;
        exp_t          e;
        cen      = c;
        kon_req  = kreq;
        kon_slot = ks;
        #1;
        check("slot", 32'(slot), 32'(m_slot));
        check("busy", 32'(busy), 32'(!m_run));
        check("sync", 32'(sync), 32'(m_run && (m_slot == 5'd0)));
        if (m_run) begin
            check("pg_phase_in", 32'(pg_phase_in), 32'(m_mem[m_slot]));
            check("pg_rst", 32'(pg_rst), 32'(m_pending[m_slot]));
        end else begin
            check("pg_rst_init", 32'(pg_rst), 32'd1);
        end

        exp_valid = m_run && c;
        if (exp_valid) begin
            nxt = m_pending[m_slot] ? '0 : m_mem[m_slot] + 20'd100;
            exp_q.push_back('{s: m_slot, op: nxt[OPW-1:0]});
            m_mem[m_slot]     = nxt;
            m_pending[m_slot] = 1'b0;
        end
        if (!m_run) m_mem[m_slot] = '0;
        exp_ack = kreq && (ks < 5'd24);
        if (exp_ack) m_pending[ks] = 1'b1;
        if (!m_run) begin
            if (m_slot == 5'd23) begin
                m_run  = 1'b1;
                m_slot = 5'd0;
            end else begin
                m_slot = m_slot + 5'd1;
            end
        end else if (c) begin
            m_slot = (m_slot == 5'd23) ? 5'd0 : m_slot + 5'd1;
        end

        @(posedge clk);
        #1;
        check("kon_ack", 32'(kon_ack), 32'(exp_ack));
        check("op_valid", 32'(op_valid), 32'(exp_valid));
        if (exp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("op_slot", 32'(op_slot), 32'(e.s));
            check("phase_op", 32'(phase_op), 32'(e.op));
        end
        @(negedge clk);
    endtask

    // Step with cen=1 until the DUT sits at slot s (bounded by two sweeps).
    task automatic run_to(input logic [4:0] s);
        for (int i = 0; i < 2 * SLOTS && m_slot != s; i++) tick(1'b1, 1'b0, 5'd0);
        check("run_to", 32'(slot), 32'(s));
    endtask

    initial begin
        rst      = 1'b1;
        cen      = 1'b0;
        kon_req  = 1'b0;
        kon_slot = 5'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_phase_op", 32'(phase_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clear sweep with cen=0: exactly 24 busy clks, then RUN at slot 0.
        for (int i = 0; i < SLOTS; i++) tick(1'b0, 1'b0, 5'd0);
        check("post_init_busy", 32'(busy), 32'd0);
        check("post_init_slot", 32'(slot), 32'd0);
        check("post_init_sync", 32'(sync), 32'd1);
        // cen=0 in RUN holds everything.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 5'd0);

        // Two full sweeps, then slot 7 has been updated twice.
        for (int i = 0; i < 2 * SLOTS; i++) tick(1'b1, 1'b0, 5'd0);
        check("wrap_sync", 32'(sync), 32'd1);
        run_to(5'd7);
        check("slot7_phase", 32'(pg_phase_in), 32'd200);

        // Key-on for slot 5 issued at slot 2.
        run_to(5'd2);
        tick(1'b1, 1'b1, 5'd5);
        check("kon5_ack", 32'(kon_ack), 32'd1);
        run_to(5'd5);
        check("kon5_pg_rst", 32'(pg_rst), 32'd1);
        tick(1'b1, 1'b0, 5'd0);
        run_to(5'd5);
        check("kon5_phase_zero", 32'(pg_phase_in), 32'd0);
        check("kon5_cleared", 32'(pg_rst), 32'd0);

        // Key-on for slot 9 on the very clk slot 9 is processed: set wins.
        run_to(5'd9);
        tick(1'b1, 1'b1, 5'd9);
        run_to(5'd9);
        check("kon9_survives", 32'(pg_rst), 32'd1);
        tick(1'b1, 1'b0, 5'd0);
        run_to(5'd9);
        check("kon9_cleared", 32'(pg_rst), 32'd0);

        // Out-of-range requests: no ack, nothing pending over a full sweep.
        tick(1'b1, 1'b1, 5'd24);
        check("kon24_no_ack", 32'(kon_ack), 32'd0);
        tick(1'b1, 1'b1, 5'd31);
        check("kon31_no_ack", 32'(kon_ack), 32'd0);
        for (int i = 0; i < SLOTS; i++) tick(1'b1, 1'b0, 5'd0);

        // Repeated request for a pending slot is acked, one pending bit.
        run_to(5'd14);
        tick(1'b1, 1'b1, 5'd12);
        tick(1'b1, 1'b1, 5'd12);
        check("kon12_repeat_ack", 32'(kon_ack), 32'd1);
        run_to(5'd12);
        check("kon12_pending", 32'(pg_rst), 32'd1);
        tick(1'b1, 1'b0, 5'd0);
        run_to(5'd12);
        check("kon12_single", 32'(pg_rst), 32'd0);

        // Random mix of cen gaps and key-on traffic.
        for (int i = 0; i < 80; i++)
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));

        // Reset mid-sweep at slot 13 with slot 20 pending and ack high.
        run_to(5'd12);
        tick(1'b1, 1'b1, 5'd20);
        check("pre_rst_ack", 32'(kon_ack), 32'd1);
        check("pre_rst_slot", 32'(slot), 32'd13);
        rst = 1'b1;
        #1;
        check("mid_rst_slot", 32'(slot), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_ack", 32'(kon_ack), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < SLOTS; i++) tick(1'b1, 1'b0, 5'd0);
        check("rerun_busy", 32'(busy), 32'd0);
        run_to(5'd20);
        check("rerun_kon20_lost", 32'(pg_rst), 32'd0);
        check("rerun_phase20", 32'(pg_phase_in), 32'd0);
        for (int i = 0; i < SLOTS; i++) tick(1'b1, 1'b0, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
